seg2bcd_scan: RTL and testbench
===============================

# seg2bcd_scan

Capture block for a multiplexed 7-segment display bus: it samples the shared segment lines and the one-hot digit-select lines, waits for each digit's pattern to hold stable, and decodes it back to a 4-bit BCD value per digit. It is the inverse of the clock bench's BCD-to-segment encoder. It sits on the display-side pins in the clock bench so the displayed time can be read back, self-checked, or forwarded.

## Interface
- `DIGITS`, 4: number of multiplexed digits; legal range 1..8.
- `STABLE`, 3: consecutive identical samples required before a commit; legal range 2..15.
- `TIMEOUT`, 65535: cycles without any commit before the capture state is invalidated; must be ≥ 1.

- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seg_in`  in  7: segment lines, active-high; bit0 = a … bit6 = g.
- `dig_in`  in  DIGITS: digit select, active-high, one-hot when valid; bit0 = rightmost digit.
- `bcd_out`  out  4*DIGITS: decoded values; digit i occupies bits [4i+3:4i].
- `err_out`  out  DIGITS: digit i's last committed pattern was illegal.
- `upd_out`  out  1: one-cycle pulse on every commit.
- `valid_out`  out  1: every digit committed since reset or since the last timeout.

## Operation
- **Input register.** `seg_in` and `dig_in` are registered every cycle. All comparisons below use these registered samples.
- **Dwell.** A dwell is a run of samples in which `dig_in` is the same one-hot value and `seg_in` is unchanged.
  - Any change in either input restarts the dwell with count = 1.
  - A `dig_in` that is zero or multi-hot ends the dwell. Count is held at 0 and no commit occurs.
- **Commit.** When count reaches `STABLE`:
  - the decoded value is written to the active digit's slot;
  - `upd_out` pulses;
  - the active digit's bit in `seen_mask` is set.
  - Only one commit happens per dwell. Count saturates at `STABLE` until the dwell restarts.
- **Decode table (segment pattern g..a → value):**
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - 0000000 (blank) → 4'hF, err = 0.
  - Any other pattern → 4'hE, err = 1.
- **`valid_out`** = AND of all `DIGITS` bits of `seen_mask`.
- **Timeout.**
  - The timeout counter clears on every commit and otherwise increments, saturating.
  - When it reaches `TIMEOUT`, `seen_mask` clears, every slot is set to 4'hF, `err_out` clears and `valid_out` drops. The counter then restarts from 0.
  - If a commit and the timeout occur on the same edge, the commit wins: the counter clears and the commit is applied normally.
- **Reset values.** `bcd_out` = all 4'hF, `err_out` = 0, `upd_out` = 0, `valid_out` = 0, `seen_mask` = 0, dwell count = 0, input registers = 0.
- **Reset mid-dwell.** Asserting reset in the middle of a dwell discards it. After release, a full `STABLE` run is needed before any commit.

## Timing
- **Commit latency.** Let the inputs be constant and legal, first captured at edge e0. Then `bcd_out`, `err_out` and `upd_out` update after edge e0+`STABLE`.
  - With `STABLE` = 3, inputs applied before edge 0 appear after edge 3.
- **`upd_out`** is high for exactly one cycle per commit.
- **`valid_out`** rises in the same cycle as the `upd_out` pulse of the commit that completes `seen_mask`.
- **Timeout effect.** The cleared state (slots 4'hF, `valid_out` low) is visible after the edge on which the counter reaches `TIMEOUT`.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.
- **Minimum dwell.** A dwell shorter than `STABLE` samples never commits. This sets the minimum scan dwell the display driver must provide.

## Test plan
1. **Reset values.** Assert `rst_n` = 0 mid-run → `bcd_out` = 16'hFFFF, `err_out` = 0, `valid_out` = 0 immediately, without a clock edge.
2. **Single commit.** DIGITS = 4, STABLE = 3. Hold `dig_in` = 0001 and `seg_in` = 1001111 → after edge 3, `bcd_out`[3:0] = 3 and `upd_out` pulses once. Keep holding for 20 more cycles → no further pulses.
3. **Full scan.** Scan digits 0..3 with patterns 1, 2, 5, 9 at 4 cycles each → `bcd_out` = 16'h9521. `valid_out` rises together with the fourth `upd_out` pulse.
4. **Glitch, illegal pattern, bad select.**
   - Change `seg_in` on the 2nd sample of a dwell → count restarts; the commit lands 3 samples after the change.
   - Pattern 1000000 → slot = 4'hE and `err_out` bit set.
   - Blank pattern 0000000 → slot = 4'hF, err = 0.
   - `dig_in` = 0011 for 10 cycles → no commit.
5. **Timeout.** TIMEOUT = 16. After a full scan, hold `dig_in` = 0 → after the 16th idle edge, `valid_out` = 0 and `bcd_out` = 16'hFFFF. A new scan rebuilds `valid_out`.
6. **Commit/timeout collision and reset mid-dwell.**
   - Arrange a commit on the same edge the counter reaches TIMEOUT → commit applied, `seen_mask` not cleared.
   - Pulse `rst_n` low after 2 stable samples → the first post-reset commit appears only after 3 fresh samples.

Source files
------------

// File: rtl/seg2bcd_scan_if.sv
// Display-side bus of the 7-segment capture block: sampled segment/select lines in,
// decoded per-digit BCD, error flags and status out.
interface seg2bcd_scan_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_in;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   err_out;
    logic                upd_out;
    logic                valid_out;

    modport master (
        output seg_in, dig_in,
        input  bcd_out, err_out, upd_out, valid_out
    );

    modport slave (
        input  seg_in, dig_in,
        output bcd_out, err_out, upd_out, valid_out
    );
endinterface

// File: rtl/seg2bcd_scan.sv
// Reads a multiplexed 7-segment display bus back into per-digit BCD values, committing
// a digit only after its select and pattern have held for STABLE registered samples.
module seg2bcd_scan #(
    parameter int DIGITS  = 4,
    parameter int STABLE  = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    seg2bcd_scan_if.slave io_bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]          r_seg;
    logic [6:0]          r_seg_prev;
    logic [DIGITS-1:0]   r_dig;
    logic [DIGITS-1:0]   r_dig_prev;
    logic [3:0]          r_cnt;
    logic [TW-1:0]       r_tmo;
    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_err;
    logic [DIGITS-1:0]   r_seen;
    logic                r_upd;
    logic                r_valid;

    logic [3:0]          w_cnt_next;
    logic                w_onehot;
    logic                w_same;
    logic                w_commit;
    logic                w_tmo_hit;
    logic [3:0]          w_val;
    logic                w_err;
    logic [DIGITS-1:0]   w_hit;
    logic [4*DIGITS-1:0] w_bcd_next;
    logic [DIGITS-1:0]   w_err_next;
    logic [DIGITS-1:0]   w_seen_next;

    // r_seg/r_dig is the current sample; r_*_prev is the one before it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg      <= '0;
            r_dig      <= '0;
            r_seg_prev <= '0;
            r_dig_prev <= '0;
        end else begin
            r_seg      <= io_bus.seg_in;
            r_dig      <= io_bus.dig_in;
            r_seg_prev <= r_seg;
            r_dig_prev <= r_dig;
        end
    end

    assign w_onehot = (r_dig != '0) && ((r_dig & (r_dig - DIGITS'(1))) == '0);
    assign w_same   = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot) begin
            w_cnt_next = 4'd0;
        end else if (!w_same || (r_cnt == 4'd0)) begin
            w_cnt_next = 4'd1;
        end else if (r_cnt < 4'(STABLE)) begin
            w_cnt_next = r_cnt + 4'd1;
        end
    end

    // Fires only on the transition into STABLE, so a held dwell commits once
    assign w_commit  = w_onehot && (w_cnt_next == 4'(STABLE)) && (r_cnt != 4'(STABLE));
    assign w_tmo_hit = !w_commit && (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_val = 4'hE;
        w_err = 1'b0;
        case (r_seg)
            7'b0111111: w_val = 4'd0;
            7'b0000110: w_val = 4'd1;
            7'b1011011: w_val = 4'd2;
            7'b1001111: w_val = 4'd3;
            7'b1100110: w_val = 4'd4;
            7'b1101101: w_val = 4'd5;
            7'b1111101: w_val = 4'd6;
            7'b0000111: w_val = 4'd7;
            7'b1111111: w_val = 4'd8;
            7'b1101111: w_val = 4'd9;
            7'b0000000: w_val = 4'hF;
            default: begin
                w_val = 4'hE;
                w_err = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign w_hit[gi]             = w_commit & r_dig[gi];
            assign w_bcd_next[4*gi +: 4] = w_hit[gi] ? w_val :
                                           (w_tmo_hit ? 4'hF : r_bcd[4*gi +: 4]);
            assign w_err_next[gi]        = w_hit[gi] ? w_err :
                                           (w_tmo_hit ? 1'b0 : r_err[gi]);
            assign w_seen_next[gi]       = w_hit[gi] | (~w_tmo_hit & r_seen[gi]);
        end
    endgenerate

    // The counter wraps to 0 on the timeout edge, so it never needs to saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_tmo   <= '0;
            r_bcd   <= '1;
            r_err   <= '0;
            r_seen  <= '0;
            r_upd   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_tmo   <= (w_commit || w_tmo_hit) ? '0 : r_tmo + TW'(1);
            r_bcd   <= w_bcd_next;
            r_err   <= w_err_next;
            r_seen  <= w_seen_next;
            r_upd   <= w_commit;
            r_valid <= &w_seen_next;
        end
    end

    assign io_bus.bcd_out   = r_bcd;
    assign io_bus.err_out   = r_err;
    assign io_bus.upd_out   = r_upd;
    assign io_bus.valid_out = r_valid;
endmodule

// File: tb/tb_seg2bcd_scan.sv
// Bench for seg2bcd_scan: a table of scan records, hand-built corner sequences and a
// random phase, all checked every cycle against a run-length based reference model.
module tb_seg2bcd_scan;
    localparam int DIGITS  = 4;
    localparam int STABLE  = 3;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
    } samp_t;

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  dig;
        int          hold;
        logic [15:0] bcd;
        logic [3:0]  err;
        logic        valid;
        logic        upd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seg2bcd_scan_if #(.DIGITS(DIGITS)) bus ();

    seg2bcd_scan #(.DIGITS(DIGITS), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    // Reference model state
    logic [6:0]  digit_pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    samp_t       hist [$];
    logic [15:0] m_bcd;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic        m_upd;
    int          m_idle;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_bcd  = 16'hFFFF;
        m_err  = '0;
        m_seen = '0;
        m_upd  = 1'b0;
        m_idle = 0;
    endtask

    // Commit when the samples captured before this edge end in a run of exactly STABLE
    task automatic model_edge(input samp_t cur);
        int         run;
        samp_t      last;
        logic [3:0] v;
        logic       e;
        run = 0;
        if (hist.size() > 0) begin
            last = hist[hist.size()-1];
            if ($countones(last.dig) == 1) begin
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != last) break;
                    run++;
                end
            end
        end
        m_upd = (run == STABLE);
        if (m_upd) begin
            v = 4'hE;
            e = 1'b1;
            if (last.seg == 7'h00) begin
                v = 4'hF;
                e = 1'b0;
            end
            for (int k = 0; k < 10; k++) begin
                if (digit_pat[k] == last.seg) begin
                    v = 4'(k);
                    e = 1'b0;
                end
            end
            for (int s = 0; s < DIGITS; s++) begin
                if (last.dig[s]) begin
                    m_bcd[s*4 +: 4] = v;
                    m_err[s]        = e;
                    m_seen[s]       = 1'b1;
                end
            end
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_bcd  = 16'hFFFF;
                m_err  = '0;
                m_seen = '0;
                m_idle = 0;
            end
        end
        hist.push_back(cur);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] d);
        samp_t cur;
        bus.seg_in = s;
        bus.dig_in = d;
        cur.seg    = s;
        cur.dig    = d;
        @(posedge clk);
        model_edge(cur);
        #1;
        chk("bcd",   16'(bus.bcd_out),   m_bcd);
        chk("err",   16'(bus.err_out),   16'(m_err));
        chk("upd",   16'(bus.upd_out),   16'(m_upd));
        chk("valid", 16'(bus.valid_out), 16'(&m_seen));
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_bcd",   16'(bus.bcd_out),   16'hFFFF);
        chk("rst_err",   16'(bus.err_out),   16'h0);
        chk("rst_upd",   16'(bus.upd_out),   16'h0);
        chk("rst_valid", 16'(bus.valid_out), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset applied and released at %0t", $time);
    endtask

    vec_t vt [7];

    task automatic apply_rec(input int i);
        for (int c = 0; c < vt[i].hold; c++) step(vt[i].seg, vt[i].dig);
        chk("rec_bcd",   16'(bus.bcd_out),   vt[i].bcd);
        chk("rec_err",   16'(bus.err_out),   16'(vt[i].err));
        chk("rec_valid", 16'(bus.valid_out), 16'(vt[i].valid));
        chk("rec_upd",   16'(bus.upd_out),   16'(vt[i].upd));
        $display("record %0d seg=%b dig=%b hold=%0d -> bcd=%h err=%b valid=%b",
                 i, vt[i].seg, vt[i].dig, vt[i].hold, bus.bcd_out, bus.err_out, bus.valid_out);
    endtask

    initial begin
        int         pulses;
        logic [6:0] rs;
        logic [3:0] rd;
        int         sel;

        vt[0] = '{7'h06, 4'b0001, 4,  16'hFFF1, 4'b0000, 1'b0, 1'b1};
        vt[1] = '{7'h5B, 4'b0010, 4,  16'hFF21, 4'b0000, 1'b0, 1'b1};
        vt[2] = '{7'h6D, 4'b0100, 4,  16'hF521, 4'b0000, 1'b0, 1'b1};
        vt[3] = '{7'h6F, 4'b1000, 4,  16'h9521, 4'b0000, 1'b1, 1'b1};
        vt[4] = '{7'h40, 4'b0001, 4,  16'h952E, 4'b0001, 1'b1, 1'b1};
        vt[5] = '{7'h00, 4'b0010, 4,  16'h95FE, 4'b0001, 1'b1, 1'b1};
        vt[6] = '{7'h06, 4'b0011, 10, 16'h95FE, 4'b0001, 1'b1, 1'b0};

        bus.seg_in = '0;
        bus.dig_in = '0;
        model_reset();
        do_reset();

        // Full scan, then idle into the timeout
        for (int i = 0; i < 4; i++) apply_rec(i);
        for (int c = 0; c < TIMEOUT - 1; c++) step(7'h00, 4'b0000);
        chk("pre_tmo_valid", 16'(bus.valid_out), 16'h1);
        chk("pre_tmo_bcd",   16'(bus.bcd_out),   16'h9521);
        step(7'h00, 4'b0000);
        chk("tmo_valid", 16'(bus.valid_out), 16'h0);
        chk("tmo_bcd",   16'(bus.bcd_out),   16'hFFFF);
        $display("timeout sequence done: bcd=%h valid=%b", bus.bcd_out, bus.valid_out);

        // Rebuild, then land a commit on the edge the idle count would reach TIMEOUT
        for (int i = 0; i < 4; i++) apply_rec(i);
        for (int c = 0; c < TIMEOUT - 4; c++) step(7'h00, 4'b0000);
        for (int c = 0; c < 4; c++) step(7'h4F, 4'b0001);
        chk("coll_upd",   16'(bus.upd_out),   16'h1);
        chk("coll_valid", 16'(bus.valid_out), 16'h1);
        chk("coll_bcd",   16'(bus.bcd_out),   16'h9523);
        $display("collision sequence done: bcd=%h valid=%b", bus.bcd_out, bus.valid_out);

        for (int i = 4; i < 7; i++) apply_rec(i);

        // Single commit from reset, then a long hold with no further pulse
        do_reset();
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            step(7'h4F, 4'b0001);
            if (bus.upd_out) pulses++;
            if (c == 3) chk("single_val", 16'(bus.bcd_out[3:0]), 16'h3);
        end
        chk("single_pulses", 16'(pulses), 16'h1);
        $display("single commit sequence done: pulses=%0d", pulses);

        // Pattern changes on the second sample of a dwell
        step(7'h06, 4'b0100);
        for (int c = 0; c < 4; c++) begin
            step(7'h7D, 4'b0100);
            chk("glitch_upd", 16'(bus.upd_out), (c == 3) ? 16'h1 : 16'h0);
        end
        chk("glitch_val", 16'(bus.bcd_out[11:8]), 16'h6);
        $display("glitch sequence done: bcd=%h", bus.bcd_out);

        // Reset after two stable samples discards the dwell
        step(7'h5B, 4'b0010);
        step(7'h5B, 4'b0010);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(7'h5B, 4'b0010);
            chk("rstdwell_upd", 16'(bus.upd_out), (c == 3) ? 16'h1 : 16'h0);
        end
        chk("rstdwell_val", 16'(bus.bcd_out[7:4]), 16'h2);
        $display("reset mid-dwell sequence done: bcd=%h", bus.bcd_out);

        // Random dwells of mixed legality and length
        for (int t = 0; t < 200; t++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 65)      rd = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 80) rd = 4'b0000;
            else begin
                rd = 4'($urandom_range(0, 15));
                if ($countones(rd) < 2) rd = rd | 4'b0011;
            end
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      rs = digit_pat[$urandom_range(0, 9)];
            else if (sel < 70) rs = 7'h00;
            else               rs = 7'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 6)); c++) step(rs, rd);
            if (t % 25 == 0)
                $display("random txn %0d seg=%b dig=%b bcd=%h valid=%b",
                         t, rs, rd, bus.bcd_out, bus.valid_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
